// File: rtl/mem_bist.sv
// mem_bist: March-style RAM self-test sequencer (write P, read P/write ~P ascending, read ~P descending).
//   clk, rst_n        : clock, asynchronous active-low reset
//   start, pattern    : run request (taken in IDLE/DONE) and test word P
//   mem_we/adr/din    : RAM write enable, address, write data
//   mem_dout          : RAM read data, combinational from mem_adr
//   busy, done        : run in progress / run complete (level)
//   fail, fail_adr    : any miscompare this run / address of the first one
//   err_count         : saturating miscompare count
module mem_bist #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] pattern,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_adr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [ADDR_WIDTH-1:0] fail_adr,
    output logic [ADDR_WIDTH+1:0] err_count
);
    typedef enum logic [2:0] {IDLE, WR0, RW, RD1, DONE} state_t;
    localparam logic [ADDR_WIDTH-1:0] LAST = '1;
    state_t state;
    logic [DATA_WIDTH-1:0] p;
    logic miss;
    // mem_adr doubles as the address counter, so the compare sees the word addressed this cycle
    assign miss = (state == RW) ? (mem_dout != p) : (state == RD1) ? (mem_dout != ~p) : 1'b0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            p         <= '0;
            mem_we    <= 1'b0;
            mem_adr   <= '0;
            mem_din   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fail      <= 1'b0;
            fail_adr  <= '0;
            err_count <= '0;
        end else begin
            if (miss) begin
                err_count <= (&err_count) ? err_count : err_count + 1'b1;
                fail      <= 1'b1;
                if (!fail) fail_adr <= mem_adr;
            end
            case (state)
                IDLE, DONE: if (start) begin
                    state     <= WR0;
                    p         <= pattern;
                    fail      <= 1'b0;
                    fail_adr  <= '0;
                    err_count <= '0;
                    mem_we    <= 1'b1;
                    mem_adr   <= '0;
                    mem_din   <= pattern;
                    busy      <= 1'b1;
                    done      <= 1'b0;
                end
                WR0: begin
                    mem_adr <= mem_adr + 1'b1;
                    if (mem_adr == LAST) begin
                        state   <= RW;
                        mem_din <= ~p;
                    end
                end
                RW: if (mem_adr == LAST) begin
                    state   <= RD1;
                    mem_we  <= 1'b0;
                    mem_din <= '0;
                end else begin
                    mem_adr <= mem_adr + 1'b1;
                end
                RD1: if (mem_adr == '0) begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end else begin
                    mem_adr <= mem_adr - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
